// File: rtl/apb_periph_demux.sv
// ---------------------------------------------------------------------------
// apb_periph_demux
//   Bridges one upstream APB requester to NUM_SLV downstream APB slaves.
//   An upstream ACCESS phase is captured, decoded against per-slave
//   base/mask windows, and replayed downstream as a fresh SETUP/ACCESS pair.
//   The slave's response is registered and returned upstream for one cycle.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   paddr_i .. penable_i  : upstream APB request
//   prdata_o, pready_o,
//   pslverr_o             : upstream APB response (valid only in RESP)
//   m_paddr_o .. m_penable_o : shared downstream request, m_psel_o one-hot
//   m_prdata_i, m_pready_i,
//   m_pslverr_i           : per-slave downstream responses
//   slv_en_i              : per-slave enable (disabled slave = decode miss)
//   timeout_o             : one-cycle pulse when a slave times out
//   err_cnt_o             : saturating count of error responses
// ---------------------------------------------------------------------------
module apb_periph_demux #(
    parameter int NUM_SLV    = 7,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] SLV_MASK = '1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [ADDR_WIDTH-1:0]              paddr_i,
    input  logic [DATA_WIDTH-1:0]              pwdata_i,
    input  logic                               pwrite_i,
    input  logic                               psel_i,
    input  logic                               penable_i,
    output logic [DATA_WIDTH-1:0]              prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    output logic [ADDR_WIDTH-1:0]              m_paddr_o,
    output logic [DATA_WIDTH-1:0]              m_pwdata_o,
    output logic                               m_pwrite_o,
    output logic [NUM_SLV-1:0]                 m_psel_o,
    output logic                               m_penable_o,
    input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NUM_SLV-1:0]                 m_pready_i,
    input  logic [NUM_SLV-1:0]                 m_pslverr_i,
    input  logic [NUM_SLV-1:0]                 slv_en_i,
    output logic                               timeout_o,
    output logic [15:0]                        err_cnt_o
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
    localparam int TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [NUM_SLV-1:0]      sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    slverr_q, slverr_d;
    logic                    abort_q, abort_d;
    logic [TCW-1:0]          tcnt_q, tcnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic                    dec_hit;
    logic [NUM_SLV-1:0]      dec_oh;
    logic [DATA_WIDTH-1:0]   slv_rdata;
    logic                    slv_ready;
    logic                    slv_err;
    logic                    active;

    // Priority decode: the first enabled window that matches wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_oh  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!dec_hit && slv_en_i[i] && ((paddr_i & SLV_MASK[i]) == SLV_BASE[i])) begin
                dec_hit   = 1'b1;
                dec_oh[i] = 1'b1;
            end
        end
    end

    // Response of the currently selected slave (sel_q is one-hot or zero).
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                slv_rdata = slv_rdata | m_prdata_i[i];
            end
        end
    end

    assign slv_ready = |(m_pready_i & sel_q);
    assign slv_err   = |(m_pslverr_i & sel_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        abort_d   = abort_q;
        tcnt_d    = tcnt_q;
        err_cnt_d = err_cnt_q;
        timeout_o = 1'b0;

        case (state_q)
            IDLE: begin
                rdata_d  = '0;
                slverr_d = 1'b0;
                abort_d  = 1'b0;
                if (psel_i && penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    sel_d   = dec_oh;
                    if (dec_hit) begin
                        state_d = SETUP;
                    end else begin
                        slverr_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            SETUP: begin
                tcnt_d  = '0;
                state_d = ACCESS;
                if (!psel_i) abort_d = 1'b1;
            end
            ACCESS: begin
                // Requester walked away: finish downstream, but stay silent upstream.
                if (!psel_i) abort_d = 1'b1;
                // A ready slave beats a timeout that fires in the same cycle.
                if (slv_ready) begin
                    rdata_d  = slv_rdata;
                    slverr_d = slv_err;
                    state_d  = RESP;
                end else if ((TIMEOUT > 0) && (tcnt_q == TMAX)) begin
                    timeout_o = 1'b1;
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    state_d   = RESP;
                end else if (tcnt_q != TMAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == RESP) && (state_q != RESP) && slverr_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            slverr_q  <= 1'b0;
            abort_q   <= 1'b0;
            tcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            slverr_q  <= slverr_d;
            abort_q   <= abort_d;
            tcnt_q    <= tcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Payload registers carry no reset; every output they feed is gated by state.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        write_q <= write_d;
        rdata_q <= rdata_d;
    end

    assign active      = (state_q == SETUP) || (state_q == ACCESS);
    assign m_psel_o    = active ? sel_q : '0;
    assign m_penable_o = (state_q == ACCESS);
    assign m_paddr_o   = active ? addr_q : '0;
    assign m_pwdata_o  = active ? wdata_q : '0;
    assign m_pwrite_o  = active & write_q;

    assign pready_o    = (state_q == RESP) && !abort_q;
    assign prdata_o    = pready_o ? rdata_q : '0;
    assign pslverr_o   = pready_o & slverr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
module tb_apb_periph_demux;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    // Slaves 1 and 3 share the 0x1000 window on purpose.
    localparam logic [NS-1:0][AW-1:0] BASE = {32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NS-1:0][AW-1:0] MASK = {NS{32'hFFFF_F000}};

    logic                    clk = 1'b0;
    logic                    rst;
    logic [AW-1:0]           paddr_i;
    logic [DW-1:0]           pwdata_i;
    logic                    pwrite_i, psel_i, penable_i;
    logic [DW-1:0]           prdata_o;
    logic                    pready_o, pslverr_o;
    logic [AW-1:0]           m_paddr_o;
    logic [DW-1:0]           m_pwdata_o;
    logic                    m_pwrite_o;
    logic [NS-1:0]           m_psel_o;
    logic                    m_penable_o;
    logic [NS-1:0][DW-1:0]   m_prdata_i;
    logic [NS-1:0]           m_pready_i, m_pslverr_i, slv_en_i;
    logic                    timeout_o;
    logic [15:0]             err_cnt_o;

    apb_periph_demux #(
        .NUM_SLV(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
        .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
        .slv_en_i(slv_en_i), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: slave i returns (i+1)*0x1000_0000 + 0xBEEF, ready after wait_cfg ACCESS cycles.
    int            wait_cfg = 0;
    logic          hang = 1'b0;
    logic [NS-1:0] slv_err_cfg = '0;
    int            acc_cnt = 0;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            m_prdata_i[i]  = DW'(32'h1000_0000 * (i + 1)) + 32'h0000_BEEF;
            m_pready_i[i]  = m_psel_o[i] & m_penable_o & !hang & (acc_cnt >= wait_cfg);
            m_pslverr_i[i] = slv_err_cfg[i];
        end
    end

    always @(posedge clk) begin
        if (m_penable_o && (m_psel_o != '0) && ((m_pready_i & m_psel_o) == '0))
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
    end

    // Scoreboard queues
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            t0;
        int            lat;
    } up_t;
    typedef struct {
        logic [NS-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        int            t0;
        int            wt;
    } dn_t;

    up_t up_q[$];
    dn_t dn_q[$];
    up_t up_m;
    dn_t dn_m;

    int rsp_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;
    int psel_cyc_cnt = 0;
    int setup_cyc = 0;
    bit bulk = 1'b0;
    int last_t0 = 0;

    // Monitor: samples on the falling edge and checks against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (timeout_o) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (m_psel_o != '0) psel_cyc_cnt++;
            if ((m_psel_o != '0) && !m_penable_o) setup_cyc = cyc;
            if (pready_o) begin
                rsp_cnt++;
                if (!bulk) begin
                    if (up_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pready: got pready_o=1 expected no response (cycle %0d)", cyc);
                    end else begin
                        up_m = up_q.pop_front();
                        chk("rsp_rdata", prdata_o, up_m.rdata);
                        chk("rsp_pslverr", pslverr_o, up_m.err);
                        chk("rsp_latency", cyc - up_m.t0, up_m.lat);
                        chk("rsp_psel_low", m_psel_o, '0);
                    end
                end
            end
            if (m_penable_o && ((m_pready_i & m_psel_o) != '0)) begin
                if (dn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_downstream: got m_psel_o=%0b expected no transfer", m_psel_o);
                end else begin
                    dn_m = dn_q.pop_front();
                    chk("dn_psel", m_psel_o, dn_m.sel);
                    chk("dn_paddr", m_paddr_o, dn_m.addr);
                    chk("dn_pwdata", m_pwdata_o, dn_m.wdata);
                    chk("dn_pwrite", m_pwrite_o, dn_m.wr);
                    chk("dn_setup_cycle", setup_cyc - dn_m.t0, 1);
                    chk("dn_done_cycle", cyc - dn_m.t0, 2 + dn_m.wt);
                end
            end
        end
    end

    task automatic wait_rsp();
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (pready_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: got no pready_o within 50 cycles expected a response");
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    // Full upstream transfer; esel=0 means no downstream completion is expected.
    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic wr,
                        input logic [NS-1:0] esel, input logic [DW-1:0] erd, input logic eerr,
                        input int elat, input int wt);
        up_t u;
        dn_t d;
        @(negedge clk);
        paddr_i = a; pwdata_i = wd; pwrite_i = wr; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        last_t0 = cyc;
        u.rdata = erd; u.err = eerr; u.t0 = cyc; u.lat = elat;
        up_q.push_back(u);
        if (esel != '0) begin
            d.sel = esel; d.addr = a; d.wdata = wd; d.wr = wr; d.t0 = cyc; d.wt = wt;
            dn_q.push_back(d);
        end
        wait_rsp();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pready"}, pready_o, 1'b0);
        chk({tag, "_prdata"}, prdata_o, '0);
        chk({tag, "_pslverr"}, pslverr_o, 1'b0);
        chk({tag, "_m_psel"}, m_psel_o, '0);
        chk({tag, "_m_penable"}, m_penable_o, 1'b0);
        chk({tag, "_m_paddr"}, m_paddr_o, '0);
        chk({tag, "_timeout"}, timeout_o, 1'b0);
        chk({tag, "_err_cnt"}, err_cnt_o, 16'h0000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    int p0, r0, t0s;

    initial begin
        rst = 1'b1;
        paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        slv_en_i = 4'b1111;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Write to slave 2, ready at once: response 3 cycles after upstream ACCESS
        wait_cfg = 0;
        xfer(32'h0000_2000, 32'hA5A5_0001, 1'b1, 4'b0100, 32'h3000_BEEF, 1'b0, 3, 0);
        // Read slave 0 with two wait cycles
        wait_cfg = 2;
        xfer(32'h0000_0010, 32'h0, 1'b0, 4'b0001, 32'h1000_BEEF, 1'b0, 5, 2);
        // Unmapped read: error at T+1, no downstream select
        wait_cfg = 0;
        p0 = psel_cyc_cnt;
        xfer(32'h8000_0000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 0);
        chk("miss_no_psel", psel_cyc_cnt - p0, 0);
        chk("miss_err_cnt", err_cnt_o, 16'd1);
        // Slave-reported error is forwarded with its data
        slv_err_cfg = 4'b0001;
        xfer(32'h0000_0020, 32'h0, 1'b0, 4'b0001, 32'h1000_BEEF, 1'b1, 3, 0);
        slv_err_cfg = 4'b0000;
        chk("slverr_err_cnt", err_cnt_o, 16'd2);
        // Overlapping windows: lowest enabled index wins
        xfer(32'h0000_1004, 32'h0, 1'b0, 4'b0010, 32'h2000_BEEF, 1'b0, 3, 0);
        slv_en_i = 4'b1101;
        xfer(32'h0000_1004, 32'h0, 1'b0, 4'b1000, 32'h4000_BEEF, 1'b0, 3, 0);
        // Disabled slave decodes as a miss
        slv_en_i = 4'b1011;
        xfer(32'h0000_2000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 0);
        slv_en_i = 4'b1111;
        chk("disabled_err_cnt", err_cnt_o, 16'd3);
        // Slave never ready: timeout fires with counter at 4 (T+6), response at T+7
        hang = 1'b1;
        r0 = to_cnt;
        xfer(32'h0000_2004, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 7, 0);
        hang = 1'b0;
        chk("timeout_pulses", to_cnt - r0, 1);
        chk("timeout_cycle", to_cyc - last_t0, 6);
        chk("timeout_err_cnt", err_cnt_o, 16'd4);
        // Slave ready in the very cycle the timeout would fire: normal response
        wait_cfg = 4;
        r0 = to_cnt;
        xfer(32'h0000_2008, 32'h0, 1'b0, 4'b0100, 32'h3000_BEEF, 1'b0, 7, 4);
        chk("race_no_timeout", to_cnt - r0, 0);
        // Requester drops psel during ACCESS: downstream completes, no pready
        wait_cfg = 3;
        @(negedge clk);
        paddr_i = 32'h0000_0040; pwdata_i = 32'h1234_5678; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        dn_m.sel = 4'b0001; dn_m.addr = 32'h0000_0040; dn_m.wdata = 32'h1234_5678; dn_m.wr = 1'b1;
        dn_m.t0 = cyc; dn_m.wt = 3;
        dn_q.push_back(dn_m);
        r0 = rsp_cnt;
        repeat (2) @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_pready", rsp_cnt - r0, 0);
        chk("abort_dn_done", dn_q.size(), 0);
        chk("abort_err_cnt", err_cnt_o, 16'd4);
        // Reset while in ACCESS
        wait_cfg = 0;
        hang = 1'b1;
        @(negedge clk);
        paddr_i = 32'h0000_2000; pwdata_i = 32'hDEAD_0001; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
        @(negedge clk);
        penable_i = 1'b1;
        t0s = cyc;
        repeat (2) @(negedge clk);
        chk("pre_rst_psel", m_psel_o, 4'b0100);
        chk("pre_rst_cycle", cyc - t0s, 2);
        rst = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        hang = 1'b0;
        xfer(32'h0000_2000, 32'hA5A5_0002, 1'b1, 4'b0100, 32'h3000_BEEF, 1'b0, 3, 0);
        // 65537 back-to-back misses saturate the error counter
        bulk = 1'b1;
        r0 = rsp_cnt;
        @(negedge clk);
        paddr_i = 32'h8000_0000; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b1;
        for (int k = 0; k < 140000 && (rsp_cnt - r0) < 65537; k++) @(negedge clk);
        psel_i = 1'b0; penable_i = 1'b0;
        repeat (3) @(negedge clk);
        bulk = 1'b0;
        chk("bulk_misses", rsp_cnt - r0, 65537);
        chk("err_cnt_sat", err_cnt_o, 16'hFFFF);
        xfer(32'h8000_0000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 0);
        chk("err_cnt_hold", err_cnt_o, 16'hFFFF);
        chk("sb_up_empty", up_q.size(), 0);
        chk("sb_dn_empty", dn_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
